// File: rtl/packet_assembler.sv
// packet_assembler: serialises one HDMI data-island packet over 32 pixel clocks.
// The header goes out on ch0 bit 2. Subpacket k goes out even/odd on ch1[k]/ch2[k].
// BCH parity bytes (polynomial 8'h83) are appended after the data bits.
module packet_assembler (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        packet_valid,
   output logic        packet_ready,
   input  logic [23:0] header,
   input  logic [55:0] sub0,
   input  logic [55:0] sub1,
   input  logic [55:0] sub2,
   input  logic [55:0] sub3,
   output logic        packet_active,
   output logic        packet_first,
   output logic        ch0_bit2,
   output logic [3:0]  ch1_data,
   output logic [3:0]  ch2_data
);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   localparam logic [4:0] LAST_SLOT     = 5'd31;
   localparam logic [4:0] HDR_DATA_END  = 5'd24;
   localparam logic [4:0] SUB_DATA_END  = 5'd28;
   localparam logic [7:0] BCH_POLY      = 8'h83;

   state_t            state_q, state_d;
   logic [4:0]        slot_q, slot_d;
   logic [23:0]       hdr_sr_q, hdr_sr_d;
   logic [3:0][55:0]  sub_sr_q, sub_sr_d;
   logic [7:0]        hdr_ecc_q, hdr_ecc_d;
   logic [3:0][7:0]   sub_ecc_q, sub_ecc_d;
   logic              active;
   logic              accept;

   // One BCH step: LFSR shifts right, feedback = lsb xor data bit.
   function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
      logic fb;
      fb = ecc[0] ^ d;
      return {1'b0, ecc[7:1]} ^ ({8{fb}} & BCH_POLY);
   endfunction

   assign active       = (state_q == S_ACTIVE);
   assign packet_ready = !active || (slot_q == LAST_SLOT);
   assign accept       = packet_valid && packet_ready;

   // State and slot counter register.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   // Next state: an accept at slot 31 restarts at slot 0 with no idle gap.
   always_comb begin
      state_d = state_q;
      slot_d  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (slot_q == LAST_SLOT && !accept) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept)      slot_d = '0;
      else if (active) slot_d = slot_q + 5'd1;
   end

   // Datapath next values: load on accept, otherwise shift data then parity.
   always_comb begin
      hdr_sr_d  = hdr_sr_q;
      hdr_ecc_d = hdr_ecc_q;
      sub_sr_d  = sub_sr_q;
      sub_ecc_d = sub_ecc_q;
      if (accept) begin
         hdr_sr_d  = header;
         hdr_ecc_d = '0;
         sub_sr_d  = {sub3, sub2, sub1, sub0};
         sub_ecc_d = '0;
      end else if (active) begin
         if (slot_q < HDR_DATA_END) begin
            hdr_ecc_d = bch_step(hdr_ecc_q, hdr_sr_q[0]);
            hdr_sr_d  = {1'b0, hdr_sr_q[23:1]};
         end else begin
            hdr_ecc_d = {1'b0, hdr_ecc_q[7:1]};
         end
         for (int unsigned k = 0; k < 4; k++) begin
            if (slot_q < SUB_DATA_END) begin
               sub_ecc_d[k] = bch_step(bch_step(sub_ecc_q[k], sub_sr_q[k][0]), sub_sr_q[k][1]);
               sub_sr_d[k]  = {2'b00, sub_sr_q[k][55:2]};
            end else begin
               sub_ecc_d[k] = {2'b00, sub_ecc_q[k][7:2]};
            end
         end
      end
   end

   // Datapath registers: shift registers and ECC LFSRs.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         hdr_sr_q  <= '0;
         hdr_ecc_q <= '0;
         sub_sr_q  <= '0;
         sub_ecc_q <= '0;
      end else begin
         hdr_sr_q  <= hdr_sr_d;
         hdr_ecc_q <= hdr_ecc_d;
         sub_sr_q  <= sub_sr_d;
         sub_ecc_q <= sub_ecc_d;
      end
   end

   // Outputs from registered state only; everything forced to 0 when idle.
   always_comb begin
      packet_active = active;
      packet_first  = active && (slot_q == 5'd0);
      ch0_bit2      = 1'b0;
      ch1_data      = '0;
      ch2_data      = '0;
      if (active) begin
         ch0_bit2 = (slot_q < HDR_DATA_END) ? hdr_sr_q[0] : hdr_ecc_q[0];
         for (int unsigned k = 0; k < 4; k++) begin
            if (slot_q < SUB_DATA_END) begin
               ch1_data[k] = sub_sr_q[k][0];
               ch2_data[k] = sub_sr_q[k][1];
            end else begin
               ch1_data[k] = sub_ecc_q[k][0];
               ch2_data[k] = sub_ecc_q[k][1];
            end
         end
      end
   end

endmodule

// File: tb/tb_packet_assembler.sv
// Testbench for packet_assembler: scoreboard of expected per-slot outputs,
// filled on each accept and drained by a negedge monitor.
module tb_packet_assembler;

   logic        clk_pixel = 1'b0;
   logic        reset_n;
   logic        packet_valid;
   logic        packet_ready;
   logic [23:0] header;
   logic [55:0] sub0, sub1, sub2, sub3;
   logic        packet_active;
   logic        packet_first;
   logic        ch0_bit2;
   logic [3:0]  ch1_data;
   logic [3:0]  ch2_data;

   always #5 clk_pixel = ~clk_pixel;

   packet_assembler dut (
      .clk_pixel     (clk_pixel),
      .reset_n       (reset_n),
      .packet_valid  (packet_valid),
      .packet_ready  (packet_ready),
      .header        (header),
      .sub0          (sub0),
      .sub1          (sub1),
      .sub2          (sub2),
      .sub3          (sub3),
      .packet_active (packet_active),
      .packet_first  (packet_first),
      .ch0_bit2      (ch0_bit2),
      .ch1_data      (ch1_data),
      .ch2_data      (ch2_data)
   );

   typedef struct packed {
      logic [4:0] slot;
      logic       first;
      logic       ch0;
      logic [3:0] ch1;
      logic [3:0] ch2;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned checks   = 0;
   int unsigned failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference BCH over the first n bits, LSB first.
   function automatic logic [7:0] bch_model(input logic [63:0] bits, input int unsigned n);
      logic [7:0] e;
      logic       fb;
      e = '0;
      for (int unsigned i = 0; i < n; i++) begin
         fb = e[0] ^ bits[i];
         e  = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
      end
      return e;
   endfunction

   function automatic logic [55:0] rnd56();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[55:0];
   endfunction

   // Expected slot stream: header word {ecc,hdr}; lane words {ecc_k,sub_k}.
   task automatic push_packet(input logic [31:0] hw, input logic [63:0] w0, input logic [63:0] w1,
                              input logic [63:0] w2, input logic [63:0] w3);
      exp_t e;
      for (int s = 0; s < 32; s++) begin
         e.slot  = 5'(s);
         e.first = (s == 0);
         e.ch0   = hw[s];
         e.ch1   = {w3[2*s], w2[2*s], w1[2*s], w0[2*s]};
         e.ch2   = {w3[2*s+1], w2[2*s+1], w1[2*s+1], w0[2*s+1]};
         sb_q.push_back(e);
      end
   endtask

   // Drive one packet when ready; expected ECC bytes supplied by caller.
   task automatic send(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                       input logic [55:0] s2, input logic [55:0] s3,
                       input logic [7:0] he, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3, input bit hold);
      int unsigned n;
      n = 0;
      forever begin
         @(negedge clk_pixel);
         if (packet_ready) break;
         n++;
         if (n > 40) begin
            check("ready_timeout", 32'(packet_ready), 32'd1);
            return;
         end
      end
      header = h; sub0 = s0; sub1 = s1; sub2 = s2; sub3 = s3;
      packet_valid = 1'b1;
      @(posedge clk_pixel);
      #1;
      push_packet({he, h}, {e0, s0}, {e1, s1}, {e2, s2}, {e3, s3});
      if (!hold) packet_valid = 1'b0;
      header = 24'($urandom());
      sub0 = rnd56(); sub1 = rnd56(); sub2 = rnd56(); sub3 = rnd56();
   endtask

   task automatic send_model(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                             input logic [55:0] s2, input logic [55:0] s3, input bit hold);
      send(h, s0, s1, s2, s3,
           bch_model(64'(h), 24),  bch_model(64'(s0), 56), bch_model(64'(s1), 56),
           bch_model(64'(s2), 56), bch_model(64'(s3), 56), hold);
   endtask

   task automatic send_random(input bit hold);
      send_model(24'($urandom()), rnd56(), rnd56(), rnd56(), rnd56(), hold);
   endtask

   // Monitor: a non-empty scoreboard means the DUT must be presenting a slot.
   always @(negedge clk_pixel) begin
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check("active", 32'(packet_active), 32'd1);
         check("first",  32'(packet_first),  32'(mon_e.first));
         check("ch0",    32'(ch0_bit2),      32'(mon_e.ch0));
         check("ch1",    32'(ch1_data),      32'(mon_e.ch1));
         check("ch2",    32'(ch2_data),      32'(mon_e.ch2));
         check("ready",  32'(packet_ready),  32'(mon_e.slot == 5'd31));
      end else begin
         check("idle_active", 32'(packet_active), 32'd0);
         check("idle_data",   32'({packet_first, ch0_bit2, ch1_data, ch2_data}), 32'd0);
         check("idle_ready",  32'(packet_ready), 32'd1);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      packet_valid = 1'b0;
      header = '0; sub0 = '0; sub1 = '0; sub2 = '0; sub3 = '0;
      repeat (3) @(posedge clk_pixel);
      #2 reset_n = 1'b1;
      repeat (2) @(posedge clk_pixel);

      // All-zero packet: every bit, including parity, is zero.
      send(24'h0, 56'h0, 56'h0, 56'h0, 56'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      repeat (36) @(posedge clk_pixel);

      // Single header bit: ch0 = 1, 23 zeros, then ECC 8'h4A LSB first.
      send(24'h000001, 56'h0, 56'h0, 56'h0, 56'h0, 8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      repeat (36) @(posedge clk_pixel);

      // Valid held high for three packets: 96 contiguous active cycles.
      send_random(1'b1);
      send_random(1'b1);
      send_random(1'b1);
      packet_valid = 1'b0;
      repeat (36) @(posedge clk_pixel);

      // Valid pulse at slot 10 with changed inputs must be ignored.
      send_random(1'b0);
      repeat (10) @(posedge clk_pixel);
      #1 packet_valid = 1'b1;
      @(posedge clk_pixel);
      #1 packet_valid = 1'b0;
      repeat (30) @(posedge clk_pixel);

      // Asynchronous reset at slot 15 discards the packet.
      send_random(1'b0);
      repeat (15) @(posedge clk_pixel);
      #1 reset_n = 1'b0;
      sb_q.delete();
      #1;
      check("rst_active", 32'(packet_active), 32'd0);
      check("rst_data",   32'({packet_first, ch0_bit2, ch1_data, ch2_data}), 32'd0);
      check("rst_ready",  32'(packet_ready), 32'd1);
      @(posedge clk_pixel);
      #2 reset_n = 1'b1;
      repeat (2) @(posedge clk_pixel);
      send_random(1'b0);
      repeat (36) @(posedge clk_pixel);

      // Bulk random packets, mostly back-to-back with occasional idle gaps.
      for (int i = 0; i < 1000; i++) begin
         send_random(1'b0);
         if (i % 50 == 49) repeat (36) @(posedge clk_pixel);
      end
      repeat (40) @(posedge clk_pixel);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
